serial_comparator5: RTL and testbench

SERIAL_COMPARATOR5 -- requirements
Module: serial_comparator5

---
 rtl/serial_comparator5.sv | 122 ++++++++++++
 tb/tb_serial_comparator5.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator5.sv
// Bit-serial unsigned magnitude comparator, MSB first, valid/ready both sides.
// Optional early exit on first differing bit: SERIAL_COMPARATOR5_EARLY_EXIT_EN.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operand pair handshake (in_ready high only in IDLE)
//   a, b                WIDTH-bit unsigned operands
//   out_valid,out_ready result handshake
//   r                   2'b00 a==b, 2'b01 a>b, 2'b10 a<b
//   busy                high whenever not IDLE
module serial_comparator5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       r,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic [1:0]       res;

  logic             bit_a;
  logic             bit_b;
  logic             diff;
  logic             last;
  logic             hit;
  logic [1:0]       res_nxt;

  assign bit_a = sa[WIDTH-1];
  assign bit_b = sb[WIDTH-1];
  assign diff  = bit_a ^ bit_b;
  assign last  = (cnt == CW'(WIDTH - 1));

  // Only the first differing bit may set the result.
  always_comb begin
    res_nxt = res;
    if (!decided && diff) begin
      res_nxt = bit_a ? 2'b01 : 2'b10;
    end
  end

`ifdef SERIAL_COMPARATOR5_EARLY_EXIT_EN
  assign hit = last || (!decided && diff);
`else
  assign hit = last;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      res       <= 2'b00;
      out_valid <= 1'b0;
      r         <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa      <= a;
            sb      <= b;
            cnt     <= '0;
            decided <= 1'b0;
            res     <= 2'b00;
            state   <= CMP;
          end
        end
        CMP: begin
          sa  <= sa << 1;
          sb  <= sb << 1;
          res <= res_nxt;
          if (!last) begin
            cnt <= cnt + 1'b1;
          end
          if (diff) begin
            decided <= 1'b1;
          end
          if (hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
            r         <= res_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            r         <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator5.sv
// Scoreboard bench for serial_comparator5 (WIDTH=5).
// Driver queues expected results; monitor checks r and latency on each output.
module tb_serial_comparator5;

  typedef struct {
    logic [1:0] r;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] r;
  logic       busy;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   ov_seen = 0;
  bit   started = 0;
  logic [1:0] cur_r = 2'b00;

  exp_t exp_q[$];
  int   acc_q[$];

  serial_comparator5 #(.WIDTH(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endfunction

  // Edge bookkeeping: acceptances and result consumption.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc_q.delete();
      ov_seen = 0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) ov_seen = 0;
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) begin
        chk("in_ready_while_done", in_ready, 1'b0);
        if (!ov_seen) begin
          ov_seen = 1;
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: r=%b, expected no output", r);
          end else begin
            exp_t e;
            int   k;
            e = exp_q.pop_front();
            k = acc_q.pop_front();
            cur_r = e.r;
            chk("result_r", r, e.r);
            chk("latency", cyc - k, e.lat);
          end
        end else begin
          chk("r_hold", r, cur_r);
        end
      end else begin
        chk("r_zero_not_done", r, 2'b00);
      end
    end
  end

  task automatic send(input logic [4:0] av, input logic [4:0] bv,
                      input logic [1:0] er, input int lp, input int le,
                      input bit push, input bit hold);
    int t;
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0, expected 1");
    end
    if (push) begin
      e.r = er;
`ifdef SERIAL_COMPARATOR5_EARLY_EXIT_EN
      e.lat = le;
`else
      e.lat = lp;
`endif
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending, expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int t;
    // Reset with a pending pair: must not be accepted.
    a = 5'b10101;
    b = 5'b01010;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_r", r, 2'b00);
    chk("rst_busy", busy, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    started = 1;
    @(negedge clk);
    chk("idle_after_rst", busy, 1'b0);

    // Fixed-latency and early-exit vectors.
    send(5'b00010, 5'b00001, 2'b01, 5, 4, 1, 0);
    drain();
    send(5'b00001, 5'b00010, 2'b10, 5, 4, 1, 0);
    drain();
    send(5'b01011, 5'b01011, 2'b00, 5, 5, 1, 0);
    drain();
    send(5'b00111, 5'b01010, 2'b10, 5, 2, 1, 0);
    drain();
    send(5'b10000, 5'b00000, 2'b01, 5, 1, 1, 0);
    drain();

    // Backpressure: result held, inputs ignored.
    out_ready = 1'b0;
    send(5'b00110, 5'b00011, 2'b01, 5, 3, 1, 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = 5'(i * 7 + 3);
      b = 5'(31 - i);
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_r", r, 2'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);

    // Reset in the middle of CMP discards the operation.
    send(5'b11011, 5'b11011, 2'b00, 5, 5, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_r", r, 2'b00);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    send(5'b01110, 5'b01110, 2'b00, 5, 5, 1, 0);
    drain();

    // Back-to-back with in_valid held high.
    send(5'b11111, 5'b00000, 2'b01, 5, 1, 1, 1);
    send(5'b00000, 5'b11111, 2'b10, 5, 1, 1, 1);
    send(5'b10110, 5'b10100, 2'b01, 5, 4, 1, 1);
    send(5'b00011, 5'b00011, 2'b00, 5, 5, 1, 1);
    send(5'b11000, 5'b11001, 2'b10, 5, 5, 1, 0);
    drain();

    repeat (8) @(negedge clk);
    chk("no_pending_expect", exp_q.size(), 0);
    chk("no_pending_accept", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
